kgp_ctrl_sequencer: RTL and testbench
=====================================

Name: kgp_ctrl_sequencer

Overview:
- Multi-cycle control sequencer for the KGP miniRISC datapath (CPU_TOP_MODULE control bundle).
- Replaces hand-driven control stimulus with an FSM: FETCH, DECODE, EXEC, MEM, WB.
- Sequences one instruction at a time from opcode/funct, with handshakes to instruction and data memory.
- Sits between the instruction register and the datapath control inputs.

Parameters:
- OPW, 6, opcode width
- FNW, 5, funct width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- opcode  in  OPW  current IR opcode, valid from DECODE onward
- funct  in  FNW  current IR funct
- imem_ready  in  1  instruction-fetch complete
- dmem_ready  in  1  data access complete
- imem_req  out  1  instruction fetch request
- ir_write  out  1  latch IR (1-cycle pulse)
- pc_inc  out  1  PC <= PC+4 (1-cycle pulse)
- pc_load  out  1  PC branch-load enable; datapath gates it with flags
- RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl, ShortBr, LongBr, MemRead, MemWrite, BranchReg  out  1 each  datapath controls
- ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg  out  2 each  datapath controls
- halted  out  1  HALT state reached
- illegal_op  out  1  1-cycle pulse on undefined opcode/funct

Behaviour:
- Reset (synchronous, active-high): state=FETCH. Every output is 0 on the cycle rst is sampled high. rst mid-operation aborts any pending imem/dmem access; MemRead and MemWrite drop the next cycle.
- Controls are combinational from {state, opcode, funct}. Every control is 0 outside the states listed below.
- FETCH: imem_req=1 until imem_ready. On imem_ready: ir_write=1, pc_inc=1, go to DECODE. Wait is unbounded.
- DECODE: 1 cycle, no controls.
  - Undefined opcode: illegal_op=1, go to FETCH (acts as NOP).
  - HALT opcode: go to HALT.
  - Otherwise go to EXEC.
- EXEC: 1 cycle; drives the datapath bundle for the class.
  - ALU-R: ALUSrc=0, ALUOp=01. funct selects CompEnbl or ShiftEnbl, ShiftType (00 sll, 01 srl, 10 sra) and ShiftAmntSel (0 imm, 1 reg).
  - addi: ALUSrc=1, ALUOp=01. compi: additionally CompEnbl=1.
  - lw/sw: ALUSrc=1, ImmSel=1, ALUOp=00.
  - Branches: ShortBr or LongBr, BranchType/JumpType from opcode, BranchReg=1 for br, pc_load=1.
  - Next state: ALU, addi, compi and bl go to WB; lw/sw go to MEM; other branches go to FETCH.
- MEM: EXEC bundle held; MemRead (lw) or MemWrite (sw) held until dmem_ready. Then lw goes to WB and sw goes to FETCH.
- WB: 1 cycle, RegWrite=1, bundle held.
  - RegDst=00 (rt); RegDst=10 for bl (r31).
  - MemToReg: 00 ALU, 01 lw, 10 bl (PC link).
  - Next state: FETCH.
- HALT: all controls 0, halted=1. Leave only via rst.
- MemRead and MemWrite are never both 1. RegWrite is only ever 1 in WB.
- CPI: ALU = fetch wait + 4; sw = 4 + dmem wait; branch = 3.

Decomposition:
- Package kgp_ctrl_pkg holds:
  - state enum
  - opcode/funct constants
  - ALUOp, ShiftType, RegDst and MemToReg encodings
  - a packed control-bundle struct
- Sub-module kgp_ctrl_decode: combinational class decode of {opcode, funct} into bundle plus class (alu/mem/br/halt/illegal). The FSM stays in the top.

Test Plan:
- rst held 3 cycles, then released with imem_ready=1 every cycle → all outputs 0 during reset; imem_req=1 first cycle after release; ir_write and pc_inc pulse together.
- addi → DECODE, EXEC (ALUSrc=1, ALUOp=01), WB (RegWrite=1, MemToReg=00); RegWrite high exactly 1 cycle, 4 cycles total.
- shrav (funct sra-var) → EXEC shows ShiftEnbl=1, ShiftType=10, ShiftAmntSel=1, CompEnbl=0.
- lw with dmem_ready delayed 3 cycles → MemRead=1 for 4 cycles, then WB with MemToReg=01; sw with the same delay → MemWrite 4 cycles, no RegWrite, back to FETCH.
- bl → pc_load=1 in EXEC, then WB with RegDst=10, MemToReg=10; undefined opcode → illegal_op one pulse, no RegWrite, next FETCH.
- rst asserted mid-MEM of sw → MemWrite=0 next cycle, state FETCH. HALT opcode → halted=1, stays high ignoring imem_ready until rst.

Source files
------------

// File: rtl/kgp_ctrl_pkg.sv
// Shared types and encodings for the KGP miniRISC control sequencer.
// Opcode/funct map, datapath control encodings and the packed control bundle.
package kgp_ctrl_pkg;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
    typedef enum logic [2:0] {C_ALU, C_MEM, C_BR, C_HALT, C_ILL} cls_e;

    localparam logic [5:0] OP_ALU   = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h01;
    localparam logic [5:0] OP_COMPI = 6'h02;
    localparam logic [5:0] OP_LW    = 6'h03;
    localparam logic [5:0] OP_SW    = 6'h04;
    localparam logic [5:0] OP_BR    = 6'h05;
    localparam logic [5:0] OP_B     = 6'h06;
    localparam logic [5:0] OP_BL    = 6'h07;
    localparam logic [5:0] OP_BZ    = 6'h08;
    localparam logic [5:0] OP_BNZ   = 6'h09;
    localparam logic [5:0] OP_BCY   = 6'h0A;
    localparam logic [5:0] OP_BNCY  = 6'h0B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [4:0] FN_ADD  = 5'd0;
    localparam logic [4:0] FN_COMP = 5'd1;
    localparam logic [4:0] FN_SLL  = 5'd2;
    localparam logic [4:0] FN_SRL  = 5'd3;
    localparam logic [4:0] FN_SRA  = 5'd4;
    localparam logic [4:0] FN_SLLV = 5'd5;
    localparam logic [4:0] FN_SRLV = 5'd6;
    localparam logic [4:0] FN_SRAV = 5'd7;

    localparam logic [1:0] ALUOP_ADDR = 2'b00;
    localparam logic [1:0] ALUOP_FUNC = 2'b01;
    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_R31 = 2'b10;
    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;
    localparam logic [1:0] BT_Z   = 2'b00;
    localparam logic [1:0] BT_NZ  = 2'b01;
    localparam logic [1:0] BT_CY  = 2'b10;
    localparam logic [1:0] BT_NCY = 2'b11;
    localparam logic [1:0] JT_REG  = 2'b01;
    localparam logic [1:0] JT_UNC  = 2'b10;
    localparam logic [1:0] JT_LINK = 2'b11;

    typedef struct packed {
        logic       ImmSel;
        logic       ALUSrc;
        logic       CompEnbl;
        logic       ShiftAmntSel;
        logic       ShiftEnbl;
        logic       ShortBr;
        logic       LongBr;
        logic       BranchReg;
        logic [1:0] ALUOp;
        logic [1:0] ShiftType;
        logic [1:0] BranchType;
        logic [1:0] JumpType;
        logic [1:0] RegDst;
        logic [1:0] MemToReg;
    } ctrl_t;

    function automatic logic [1:0] shift_type(input logic [4:0] fn);
        case (fn)
            FN_SLL, FN_SLLV: return SH_SLL;
            FN_SRL, FN_SRLV: return SH_SRL;
            default:         return SH_SRA;
        endcase
    endfunction

endpackage

// File: rtl/kgp_ctrl_sequencer_if.sv
// Sequencer <-> IR / memory / datapath bundle. master = sequencer side.
interface kgp_ctrl_sequencer_if #(parameter int OPW = 6, parameter int FNW = 5);
    logic [OPW-1:0] opcode;
    logic [FNW-1:0] funct;
    logic           imem_ready, dmem_ready;
    logic           imem_req, ir_write, pc_inc, pc_load;
    logic           RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl;
    logic           ShortBr, LongBr, MemRead, MemWrite, BranchReg;
    logic [1:0]     ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg;
    logic           halted, illegal_op;

    modport master (
        input  opcode, funct, imem_ready, dmem_ready,
        output imem_req, ir_write, pc_inc, pc_load, RegWrite, ImmSel, ALUSrc, CompEnbl,
               ShiftAmntSel, ShiftEnbl, ShortBr, LongBr, MemRead, MemWrite, BranchReg,
               ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg, halted, illegal_op
    );

    modport slave (
        output opcode, funct, imem_ready, dmem_ready,
        input  imem_req, ir_write, pc_inc, pc_load, RegWrite, ImmSel, ALUSrc, CompEnbl,
               ShiftAmntSel, ShiftEnbl, ShortBr, LongBr, MemRead, MemWrite, BranchReg,
               ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg, halted, illegal_op
    );
endinterface

// File: rtl/kgp_ctrl_decode.sv
// Combinational class decode of {opcode, funct} into the datapath control bundle.
module kgp_ctrl_decode
    import kgp_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int FNW = 5
) (
    input  logic [OPW-1:0] opcode_i,
    input  logic [FNW-1:0] funct_i,
    output ctrl_t          ctrl_o,
    output cls_e           cls_o,
    output logic           wb_o,
    output logic           store_o
);

    always_comb begin
        ctrl_o  = '0;
        cls_o   = C_ILL;
        wb_o    = 1'b0;
        store_o = 1'b0;
        case (opcode_i)
            OPW'(OP_ALU): begin
                cls_o        = C_ALU;
                wb_o         = 1'b1;
                ctrl_o.ALUOp = ALUOP_FUNC;
                case (funct_i)
                    FNW'(FN_ADD):  ctrl_o.CompEnbl = 1'b0;
                    FNW'(FN_COMP): ctrl_o.CompEnbl = 1'b1;
                    FNW'(FN_SLL), FNW'(FN_SRL), FNW'(FN_SRA),
                    FNW'(FN_SLLV), FNW'(FN_SRLV), FNW'(FN_SRAV): begin
                        ctrl_o.ShiftEnbl    = 1'b1;
                        ctrl_o.ShiftAmntSel = (funct_i >= FNW'(FN_SLLV));
                        ctrl_o.ShiftType    = shift_type(5'(funct_i));
                    end
                    default: begin
                        ctrl_o = '0;
                        cls_o  = C_ILL;
                        wb_o   = 1'b0;
                    end
                endcase
            end
            OPW'(OP_ADDI), OPW'(OP_COMPI): begin
                cls_o           = C_ALU;
                wb_o            = 1'b1;
                ctrl_o.ALUSrc   = 1'b1;
                ctrl_o.ALUOp    = ALUOP_FUNC;
                ctrl_o.CompEnbl = (opcode_i == OPW'(OP_COMPI));
            end
            OPW'(OP_LW), OPW'(OP_SW): begin
                cls_o           = C_MEM;
                store_o         = (opcode_i == OPW'(OP_SW));
                wb_o            = (opcode_i == OPW'(OP_LW));
                ctrl_o.ALUSrc   = 1'b1;
                ctrl_o.ImmSel   = 1'b1;
                ctrl_o.ALUOp    = ALUOP_ADDR;
                ctrl_o.MemToReg = (opcode_i == OPW'(OP_LW)) ? M2R_MEM : M2R_ALU;
            end
            OPW'(OP_BR): begin
                cls_o            = C_BR;
                ctrl_o.LongBr    = 1'b1;
                ctrl_o.BranchReg = 1'b1;
                ctrl_o.JumpType  = JT_REG;
            end
            OPW'(OP_B): begin
                cls_o           = C_BR;
                ctrl_o.LongBr   = 1'b1;
                ctrl_o.JumpType = JT_UNC;
            end
            // bl is the only branch that writes back: link PC into r31
            OPW'(OP_BL): begin
                cls_o           = C_BR;
                wb_o            = 1'b1;
                ctrl_o.LongBr   = 1'b1;
                ctrl_o.JumpType = JT_LINK;
                ctrl_o.RegDst   = RD_R31;
                ctrl_o.MemToReg = M2R_PC;
            end
            OPW'(OP_BZ), OPW'(OP_BNZ), OPW'(OP_BCY), OPW'(OP_BNCY): begin
                cls_o          = C_BR;
                ctrl_o.ShortBr = 1'b1;
                case (opcode_i)
                    OPW'(OP_BZ):  ctrl_o.BranchType = BT_Z;
                    OPW'(OP_BNZ): ctrl_o.BranchType = BT_NZ;
                    OPW'(OP_BCY): ctrl_o.BranchType = BT_CY;
                    default:      ctrl_o.BranchType = BT_NCY;
                endcase
            end
            OPW'(OP_HALT): cls_o = C_HALT;
            default:       cls_o = C_ILL;
        endcase
    end

endmodule

// File: rtl/kgp_ctrl_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the KGP miniRISC datapath.
// IR holds opcode/funct from DECODE onward, so decode stays combinational on it.
module kgp_ctrl_sequencer
    import kgp_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int FNW = 5
) (
    input logic                   clk,
    input logic                   rst,
    kgp_ctrl_sequencer_if.master  bus_if
);

    state_e state_q;
    ctrl_t  dec_ctrl, c;
    cls_e   dec_cls;
    logic   dec_wb, dec_store;
    logic   imem_req, ir_write, pc_inc, pc_load, reg_write, mem_rd, mem_wr, halted, illegal;

    kgp_ctrl_decode #(.OPW(OPW), .FNW(FNW)) u_dec (
        .opcode_i (bus_if.opcode),
        .funct_i  (bus_if.funct),
        .ctrl_o   (dec_ctrl),
        .cls_o    (dec_cls),
        .wb_o     (dec_wb),
        .store_o  (dec_store)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  if (bus_if.imem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    case (dec_cls)
                        C_ILL:   state_q <= S_FETCH;
                        C_HALT:  state_q <= S_HALT;
                        default: state_q <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    if (dec_cls == C_MEM) state_q <= S_MEM;
                    else if (dec_wb)      state_q <= S_WB;
                    else                  state_q <= S_FETCH;
                end
                S_MEM:    if (bus_if.dmem_ready) state_q <= dec_store ? S_FETCH : S_WB;
                S_WB:     state_q <= S_FETCH;
                S_HALT:   state_q <= S_HALT;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Outputs are gated by rst so everything reads 0 while reset is applied.
    always_comb begin
        c         = '0;
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        reg_write = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = bus_if.imem_ready;
                    pc_inc   = bus_if.imem_ready;
                end
                S_DECODE: illegal = (dec_cls == C_ILL);
                S_EXEC: begin
                    c          = dec_ctrl;
                    c.RegDst   = RD_RT;
                    c.MemToReg = M2R_ALU;
                    pc_load    = (dec_cls == C_BR);
                end
                S_MEM: begin
                    c          = dec_ctrl;
                    c.RegDst   = RD_RT;
                    c.MemToReg = M2R_ALU;
                    mem_rd     = !dec_store;
                    mem_wr     = dec_store;
                end
                S_WB: begin
                    c         = dec_ctrl;
                    reg_write = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: halted = 1'b0;
            endcase
        end
    end

    assign bus_if.imem_req     = imem_req;
    assign bus_if.ir_write     = ir_write;
    assign bus_if.pc_inc       = pc_inc;
    assign bus_if.pc_load      = pc_load;
    assign bus_if.RegWrite     = reg_write;
    assign bus_if.MemRead      = mem_rd;
    assign bus_if.MemWrite     = mem_wr;
    assign bus_if.halted       = halted;
    assign bus_if.illegal_op   = illegal;
    assign bus_if.ImmSel       = c.ImmSel;
    assign bus_if.ALUSrc       = c.ALUSrc;
    assign bus_if.CompEnbl     = c.CompEnbl;
    assign bus_if.ShiftAmntSel = c.ShiftAmntSel;
    assign bus_if.ShiftEnbl    = c.ShiftEnbl;
    assign bus_if.ShortBr      = c.ShortBr;
    assign bus_if.LongBr       = c.LongBr;
    assign bus_if.BranchReg    = c.BranchReg;
    assign bus_if.ALUOp        = c.ALUOp;
    assign bus_if.ShiftType    = c.ShiftType;
    assign bus_if.BranchType   = c.BranchType;
    assign bus_if.JumpType     = c.JumpType;
    assign bus_if.RegDst       = c.RegDst;
    assign bus_if.MemToReg     = c.MemToReg;

endmodule

// File: tb/tb_kgp_ctrl_sequencer.sv
// Scoreboard bench: stimulus pushes the expected per-cycle control snapshot,
// a negedge monitor pops and compares it against the sequencer outputs.
module tb_kgp_ctrl_sequencer;
    import kgp_ctrl_pkg::*;

    typedef struct packed {
        logic imem_req, ir_write, pc_inc, pc_load, RegWrite, ImmSel, ALUSrc, CompEnbl;
        logic ShiftAmntSel, ShiftEnbl, ShortBr, LongBr, MemRead, MemWrite, BranchReg;
        logic halted, illegal_op;
        logic [1:0] ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg;
    } out_t;

    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_BL = 4, K_HALT = 5, K_ILL = 6;

    logic  clk, rst, mon_on;
    int    n_chk, n_fail;
    out_t  exp_q[$];
    string lbl_q[$];
    out_t  m_act, m_exp;
    string m_lbl;

    kgp_ctrl_sequencer_if #(.OPW(6), .FNW(5)) bus();
    kgp_ctrl_sequencer #(.OPW(6), .FNW(5)) dut (.clk(clk), .rst(rst), .bus_if(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: instruction kind straight from the opcode map.
    function automatic int kind(input logic [5:0] op, input logic [4:0] fn);
        if (op == OP_HALT)              return K_HALT;
        if (op > OP_BNCY)               return K_ILL;
        if (op == OP_ALU && fn > 5'd7)  return K_ILL;
        if (op == OP_LW)                return K_LW;
        if (op == OP_SW)                return K_SW;
        if (op == OP_BL)                return K_BL;
        if (op >= OP_BR)                return K_BR;
        return K_ALU;
    endfunction

    // Reference EXEC/MEM bundle (RegDst/MemToReg belong to WB only).
    function automatic out_t bundle(input logic [5:0] op, input logic [4:0] fn);
        out_t b;
        b = '0;
        if (op == OP_ALU) begin
            b.ALUOp    = 2'b01;
            b.CompEnbl = (fn == 5'd1);
            if (fn >= 5'd2) begin
                b.ShiftEnbl    = 1'b1;
                b.ShiftAmntSel = (fn >= 5'd5);
                b.ShiftType    = 2'((int'(fn) - 2) % 3);
            end
        end else if (op == OP_ADDI || op == OP_COMPI) begin
            b.ALUSrc   = 1'b1;
            b.ALUOp    = 2'b01;
            b.CompEnbl = (op == OP_COMPI);
        end else if (op == OP_LW || op == OP_SW) begin
            b.ALUSrc = 1'b1;
            b.ImmSel = 1'b1;
        end else if (op >= OP_BZ) begin
            b.ShortBr    = 1'b1;
            b.BranchType = 2'(op - OP_BZ);
        end else begin
            b.LongBr    = 1'b1;
            b.BranchReg = (op == OP_BR);
            b.JumpType  = 2'(op - OP_BR + 6'd1);
        end
        return b;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic step(input logic ir, input logic dr, input out_t e, input string l);
        bus.imem_ready = ir;
        bus.dmem_ready = dr;
        exp_q.push_back(e);
        lbl_q.push_back(l);
        @(posedge clk);
        #1;
    endtask

    // One instruction: fw fetch-wait cycles, dw dmem-wait cycles, reset on mem-wait cycle ab (-1: never).
    task automatic run(input logic [5:0] op, input logic [4:0] fn, input int fw, input int dw, input int ab);
        out_t e, x;
        int   k;
        k = kind(op, fn);
        for (int i = 0; i < fw; i++) begin
            bus.opcode = 6'($urandom);
            bus.funct  = 5'($urandom);
            e = '0; e.imem_req = 1'b1;
            step(1'b0, rb(), e, "fetch_wait");
        end
        e = '0; e.imem_req = 1'b1; e.ir_write = 1'b1; e.pc_inc = 1'b1;
        step(1'b1, rb(), e, "fetch");
        bus.opcode = op;
        bus.funct  = fn;
        e = '0; e.illegal_op = (k == K_ILL);
        step(rb(), rb(), e, "decode");
        if (k == K_ILL) return;
        if (k == K_HALT) begin
            e = '0; e.halted = 1'b1;
            for (int i = 0; i < 4; i++) step(1'b1, rb(), e, "halt");
            rst = 1'b1;
            step(rb(), rb(), '0, "halt_rst");
            rst = 1'b0;
            return;
        end
        x = bundle(op, fn);
        e = x; e.pc_load = (k == K_BR || k == K_BL);
        step(rb(), rb(), e, "exec");
        if (k == K_LW || k == K_SW) begin
            e = x; e.MemRead = (k == K_LW); e.MemWrite = (k == K_SW);
            for (int i = 0; i < dw; i++) begin
                if (i == ab) begin
                    rst = 1'b1;
                    step(rb(), rb(), '0, "mem_rst");
                    rst = 1'b0;
                    return;
                end
                step(rb(), 1'b0, e, "mem_wait");
            end
            step(rb(), 1'b1, e, "mem");
            if (k == K_SW) return;
        end
        if (k == K_BR) return;
        e = x; e.RegWrite = 1'b1;
        e.MemToReg = (k == K_LW) ? 2'b01 : (k == K_BL) ? 2'b10 : 2'b00;
        e.RegDst   = (k == K_BL) ? 2'b10 : 2'b00;
        step(rb(), rb(), e, "wb");
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            m_act = '0;
            m_act.imem_req = bus.imem_req;   m_act.ir_write = bus.ir_write;
            m_act.pc_inc = bus.pc_inc;       m_act.pc_load = bus.pc_load;
            m_act.RegWrite = bus.RegWrite;   m_act.ImmSel = bus.ImmSel;
            m_act.ALUSrc = bus.ALUSrc;       m_act.CompEnbl = bus.CompEnbl;
            m_act.ShiftAmntSel = bus.ShiftAmntSel; m_act.ShiftEnbl = bus.ShiftEnbl;
            m_act.ShortBr = bus.ShortBr;     m_act.LongBr = bus.LongBr;
            m_act.MemRead = bus.MemRead;     m_act.MemWrite = bus.MemWrite;
            m_act.BranchReg = bus.BranchReg; m_act.halted = bus.halted;
            m_act.illegal_op = bus.illegal_op; m_act.ALUOp = bus.ALUOp;
            m_act.RegDst = bus.RegDst;       m_act.ShiftType = bus.ShiftType;
            m_act.BranchType = bus.BranchType; m_act.JumpType = bus.JumpType;
            m_act.MemToReg = bus.MemToReg;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty t=%0t got=%h required=<an expected entry>", $time, m_act);
            end else begin
                m_exp = exp_q.pop_front();
                m_lbl = lbl_q.pop_front();
                if (m_act !== m_exp) begin
                    n_fail++;
                    $display("FAIL %s t=%0t got=%h required=%h", m_lbl, $time, m_act, m_exp);
                end
            end
        end
    end

    initial begin
        logic [5:0] op;
        logic [4:0] fn;
        int         r;
        n_chk = 0; n_fail = 0; mon_on = 1'b0;
        rst = 1'b1;
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
        bus.opcode = '0; bus.funct = '0;
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, "reset");
        rst = 1'b0;
        run(OP_ADDI, 5'd0, 0, 0, -1);
        run(OP_ALU, FN_SRAV, 1, 0, -1);
        run(OP_LW, 5'd0, 0, 3, -1);
        run(OP_SW, 5'd0, 2, 3, -1);
        run(OP_BL, 5'd0, 0, 0, -1);
        run(6'h15, 5'd0, 0, 0, -1);
        run(OP_COMPI, 5'd0, 0, 0, -1);
        run(OP_BNZ, 5'd0, 1, 0, -1);
        run(OP_SW, 5'd0, 0, 4, 2);
        run(OP_ADDI, 5'd0, 1, 0, -1);
        run(OP_HALT, 5'd0, 0, 0, -1);
        for (int n = 0; n < 70; n++) begin
            r  = $urandom_range(0, 15);
            fn = 5'($urandom_range(0, 9));
            if (r < 12)       op = 6'(r);
            else if (r == 12) op = 6'($urandom_range(12, 62));
            else if (r < 15)  op = OP_ALU;
            else              op = OP_HALT;
            run(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end
        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
